// File: rtl/rainbow_sequencer.sv
// rainbow_sequencer: hue-wheel controller for the shared RGB PWM datapath.
// Owns the common PWM period counter and steps a 6-phase hue machine. The
// per-channel duty words are registered and only move on the edge that takes
// the PWM counter back to 0, so a channel never glitches mid-period.
module rainbow_sequencer #(
  parameter int PWM_INTERVAL     = 1200,
  parameter int DUTY_STEP        = 12,
  parameter int PERIODS_PER_STEP = 17,
  localparam int DW              = $clog2(PWM_INTERVAL + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [DW-1:0] pwm_cnt,
  output logic          period_start,
  output logic [DW-1:0] duty_r,
  output logic [DW-1:0] duty_g,
  output logic [DW-1:0] duty_b,
  output logic [2:0]    phase
);

  // period counter needs at least one bit even when every period is a step
  localparam int PW = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;

  // one extra bit so level + DUTY_STEP can never overflow before saturation
  typedef logic [DW:0] wide_t;

  typedef struct packed {
    logic [DW-1:0] r;
    logic [DW-1:0] g;
    logic [DW-1:0] b;
  } duty_t;

  localparam logic [DW-1:0] FULL     = DW'(PWM_INTERVAL);
  localparam logic [DW-1:0] CNT_LAST = DW'(PWM_INTERVAL - 1);
  localparam wide_t         FULL_W   = wide_t'(PWM_INTERVAL);
  localparam wide_t         STEP_W   = wide_t'(DUTY_STEP);
  localparam logic [PW-1:0] PER_LAST = PW'(PERIODS_PER_STEP - 1);

  // Hue wheel: one channel held at full scale, one ramping, one off.
  // Adjacent phases agree at their boundary (end L=M equals start L=0).
  function automatic duty_t duty_table(input logic [2:0] ph, input logic [DW-1:0] lvl);
    duty_t d;
    d.r = FULL;
    d.g = '0;
    d.b = '0;
    case (ph)
      3'd0: begin d.r = FULL;       d.g = lvl;        d.b = '0;         end
      3'd1: begin d.r = FULL - lvl; d.g = FULL;       d.b = '0;         end
      3'd2: begin d.r = '0;         d.g = FULL;       d.b = lvl;        end
      3'd3: begin d.r = '0;         d.g = FULL - lvl; d.b = FULL;       end
      3'd4: begin d.r = lvl;        d.g = '0;         d.b = FULL;       end
      3'd5: begin d.r = FULL;       d.g = '0;         d.b = FULL - lvl; end
      default: begin d.r = FULL;    d.g = '0;         d.b = '0;         end
    endcase
    return d;
  endfunction

  logic [DW-1:0] pwm_cnt_r;
  logic          period_start_r;
  logic [PW-1:0] period_cnt_r;
  logic [DW-1:0] level_r;
  logic [2:0]    phase_r;
  duty_t         duty_set_r;

  logic [DW-1:0] pwm_cnt_nxt_s;
  logic [PW-1:0] period_cnt_nxt_s;
  logic [DW-1:0] level_nxt_s;
  logic [2:0]    phase_nxt_s;
  duty_t         duty_nxt_s;
  wide_t         level_sum_s;
  logic          wrap_s;
  logic          step_s;

  // Next-state: free-running PWM counter, gated period counter, hue step.
  always_comb begin
    pwm_cnt_nxt_s    = pwm_cnt_r;
    period_cnt_nxt_s = period_cnt_r;
    level_nxt_s      = level_r;
    phase_nxt_s      = phase_r;
    duty_nxt_s       = duty_set_r;
    step_s           = 1'b0;
    wrap_s           = (pwm_cnt_r == CNT_LAST);
    level_sum_s      = wide_t'(level_r) + STEP_W;

    if (wrap_s) begin
      pwm_cnt_nxt_s = '0;
    end else begin
      pwm_cnt_nxt_s = pwm_cnt_r + DW'(1);
    end

    if (wrap_s && en) begin
      if (period_cnt_r == PER_LAST) begin
        period_cnt_nxt_s = '0;
        step_s           = 1'b1;
      end else begin
        period_cnt_nxt_s = period_cnt_r + PW'(1);
      end
    end else begin
      period_cnt_nxt_s = period_cnt_r;
    end

    if (step_s) begin
      if (level_r == FULL) begin
        level_nxt_s = '0;
        phase_nxt_s = (phase_r == 3'd5) ? 3'd0 : phase_r + 3'd1;
      end else begin
        phase_nxt_s = phase_r;
        if (level_sum_s > FULL_W) begin
          level_nxt_s = FULL;
        end else begin
          level_nxt_s = level_sum_s[DW-1:0];
        end
      end
      // duty follows the post-step phase/level so it lands with pwm_cnt == 0
      duty_nxt_s = duty_table(phase_nxt_s, level_nxt_s);
    end else begin
      level_nxt_s = level_r;
      phase_nxt_s = phase_r;
      duty_nxt_s  = duty_set_r;
    end
  end

  // State and output registers; reset forces the wheel back to pure red.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_r      <= '0;
      period_start_r <= 1'b1;
      period_cnt_r   <= '0;
      level_r        <= '0;
      phase_r        <= 3'd0;
      duty_set_r.r   <= FULL;
      duty_set_r.g   <= '0;
      duty_set_r.b   <= '0;
    end else begin
      pwm_cnt_r      <= pwm_cnt_nxt_s;
      period_start_r <= (pwm_cnt_nxt_s == '0);
      period_cnt_r   <= period_cnt_nxt_s;
      level_r        <= level_nxt_s;
      phase_r        <= phase_nxt_s;
      duty_set_r     <= duty_nxt_s;
    end
  end

  assign pwm_cnt      = pwm_cnt_r;
  assign period_start = period_start_r;
  assign duty_r       = duty_set_r.r;
  assign duty_g       = duty_set_r.g;
  assign duty_b       = duty_set_r.b;
  assign phase        = phase_r;

endmodule
